if_fetch: RTL and testbench

- Instruction-fetch stage. Generates the PC, issues requests to instruction memory, buffers returned words in a small in-order prefetch queue, and presents if_pc/if_inst to the IF/ID pipeline register.
- Obeys the same stall/flush controls as IF/ID.
- Handles branch redirects by discarding stale in-flight responses.

---
 rtl/if_fetch_pkg.sv | 15 +
 rtl/if_fetch_if.sv | 37 +++
 rtl/if_fetch_queue.sv | 72 +++++++
 rtl/if_fetch.sv | 117 +++++++++++
 tb/tb_if_fetch.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_fetch_pkg;

    localparam int          REG_BUS_W = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic [31:0] NOP_INST  = 32'h0;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: pipeline controls, instruction-memory handshake, IF/ID head outputs.
// Latency: n/a (wiring only).
// Backpressure: stall holds the head; imem_gnt throttles requests.
//   master: the fetch stage (drives imem_req/imem_addr and if_pc/if_inst/if_valid)
//   slave : the environment (pipeline control, instruction memory, IF/ID consumer)
interface if_fetch_if
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              flush;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       if_inst;
    logic              if_valid;

    modport master (
        input  stall, flush, branch_taken, branch_target,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output imem_req, imem_addr,
        output if_pc, if_inst, if_valid
    );

    modport slave (
        output stall, flush, branch_taken, branch_target,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr,
        input  if_pc, if_inst, if_valid
    );
endinterface

// File: rtl/if_fetch_queue.sv
// In-order prefetch FIFO of {pc, inst}; head is presented combinationally (zero when empty).
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller never pushes when full. clear wins over push/pop.
//   ports: push/push_dat, pop, clear, count, head_vld/head_dat
module if_fetch_queue
    import if_fetch_pkg::*;
#(
    parameter int W     = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             head_vld,
    output logic [W-1:0]     head_dat
);
    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count    = count_q;
    assign head_vld = (count_q != '0);
    assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC generation, imem request issue, prefetch queue, redirect with stale-response drain.
// Latency: redirect in cycle N issues the new address in N+1 (no drain); the word reaches if_* two cycles after its grant.
// Backpressure: stall holds the head; requests stop once queued + in-flight words fill the queue; imem_gnt low holds imem_addr.
//   ports: clk, rst (async, active-high), bus (if_fetch_if.master)
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 2    // power of two, 2..8
) (
    input  logic       clk,
    input  logic       rst,
    if_fetch_if.master bus
);
    localparam int               CNT_W    = $clog2(QDEPTH + 1);
    localparam int               QW       = ADDR_W + 32;
    localparam logic [CNT_W:0]   QDEPTH_C = (CNT_W + 1)'(QDEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drain_q, drain_d;

    logic              redirect;
    logic              issue;
    logic              push;
    logic              pop;
    logic              rsp_live;
    logic              rsp_stale;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W-1:0]  q_count;
    logic              q_head_vld;
    logic [QW-1:0]     q_head_dat;

    assign redirect  = bus.flush | bus.branch_taken;
    assign pop       = q_head_vld & ~bus.stall & ~redirect;
    // Responses belong to the drain count first; only once it is zero are they live.
    assign rsp_stale = bus.imem_rvalid & (drain_q != '0);
    assign rsp_live  = bus.imem_rvalid & (drain_q == '0);
    // A live word arriving on a redirect cycle is already stale: drop it.
    assign push      = rsp_live & ~redirect;

    // Slot accounting counts the entry leaving this cycle as free, so a
    // 1-cycle memory with a draining consumer sustains one word per cycle.
    // Queued + in-flight never exceeds QDEPTH, so a push never meets a full queue.
    assign occupancy = {1'b0, q_count} - {{CNT_W{1'b0}}, pop} + {1'b0, outstanding_q};

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drain_d       = drain_q;
        issue         = ~rst && (state_q == FETCH) && ~redirect && (occupancy < QDEPTH_C);

        if (redirect) begin
            fetch_pc_d    = bus.branch_target;
            rsp_pc_d      = bus.branch_target;
            // Everything still in flight becomes stale, net of this cycle's response.
            drain_d       = drain_q - CNT_W'(rsp_stale) + outstanding_q - CNT_W'(rsp_live);
            outstanding_d = '0;
            state_d       = (drain_d != '0) ? DRAIN : FETCH;
        end else begin
            if (issue && bus.imem_gnt) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + ADDR_W'(4);
            end
            outstanding_d = outstanding_q + CNT_W'(issue && bus.imem_gnt) - CNT_W'(rsp_live);
            drain_d       = drain_q - CNT_W'(rsp_stale);
            if ((state_q == DRAIN) && (drain_d == '0)) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drain_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drain_q       <= drain_d;
        end
    end

    if_fetch_queue #(
        .W     (QW),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({rsp_pc_q, bus.imem_rdata}),
        .pop      (pop),
        .clear    (redirect),
        .count    (q_count),
        .head_vld (q_head_vld),
        .head_dat (q_head_dat)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.if_valid  = q_head_vld;
    assign bus.if_pc     = q_head_dat[QW-1:32];
    assign bus.if_inst   = q_head_vld ? q_head_dat[31:0] : NOP_INST;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: cycle table plus scoreboarded drain/redirect sequences.
// Latency: memory model answers mem_lat cycles after each grant with inst = ~addr.
// Backpressure: stall/gnt driven from the table and sequences.
module tb_if_fetch;
    import if_fetch_pkg::*;

    localparam int QDEPTH = 2;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   mem_lat = 1;

    if_fetch_if #(.ADDR_W(32)) bus ();

    if_fetch #(
        .ADDR_W   (32),
        .RESET_PC (32'h0),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // ---------------- instruction memory model ----------------
    logic        cap_vld;
    logic [31:0] cap_addr;
    logic        pipe_vld  [8];
    logic [31:0] pipe_addr [8];

    always @(negedge clk) begin
        cap_vld  = bus.imem_req & bus.imem_gnt & ~rst;
        cap_addr = bus.imem_addr;
    end

    always @(posedge clk) begin
        #2;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                pipe_vld[i]  = 1'b0;
                pipe_addr[i] = 32'h0;
            end
        end else begin
            for (int i = 7; i > 0; i--) begin
                pipe_vld[i]  = pipe_vld[i-1];
                pipe_addr[i] = pipe_addr[i-1];
            end
            pipe_vld[0]  = cap_vld;
            pipe_addr[0] = cap_addr;
        end
        bus.imem_rvalid = pipe_vld[mem_lat-1];
        bus.imem_rdata  = pipe_vld[mem_lat-1] ? ~pipe_addr[mem_lat-1] : 32'h0;
    end

    // ---------------- scoreboard of consumed instructions ----------------
    logic [31:0] sb_q[$];
    logic        sb_en = 1'b0;

    always @(negedge clk) begin
        logic [31:0] exp_pc;
        if (sb_en && !rst && bus.if_valid && !bus.stall && !bus.flush && !bus.branch_taken) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: consumed pc %h, expected none", bus.if_pc);
            end else begin
                exp_pc = sb_q.pop_front();
                chk("sb_pc", bus.if_pc, exp_pc);
                chk("sb_inst", bus.if_inst, ~exp_pc);
            end
        end
    end

    // A response must never find the queue full.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (dut.u_queue.push && (32'(dut.u_queue.count) == QDEPTH)) begin
                errors++;
                $display("FAIL overflow: push with count %0d, limit %0d", dut.u_queue.count, QDEPTH);
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        rst, stall, flush, br;
        logic [31:0] tgt;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } row_t;

    function automatic row_t mk(input logic r, s, f, b, input logic [31:0] t, input logic g,
                                input logic eq, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        row_t x;
        x.rst = r; x.stall = s; x.flush = f; x.br = b; x.tgt = t; x.gnt = g;
        x.req = eq; x.addr = ea; x.vld = ev; x.pc = ep;
        return x;
    endfunction

    task automatic drive(input logic r, s, f, b, input logic [31:0] t, input logic g);
        @(posedge clk);
        #1;
        rst               = r;
        bus.stall         = s;
        bus.flush         = f;
        bus.branch_taken  = b;
        bus.branch_target = t;
        bus.imem_gnt      = g;
    endtask

    // Two requests in flight under a 3-cycle memory, then a redirect (optionally a
    // second one during the drain). Stale words must never reach if_*.
    task automatic drain_seq(input logic [31:0] t1, input logic dbl, input logic [31:0] t2);
        logic [31:0] fin;
        fin     = dbl ? t2 : t1;
        mem_lat = 3;
        drive(1, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_vld", 32'(bus.if_valid), 0);
        chk("rst_pc", bus.if_pc, 0);
        chk("rst_addr", bus.imem_addr, 0);
        sb_q.delete();
        sb_en = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, t1, 1);
        for (int k = 0; k < 3; k++) sb_q.push_back(t1 + 32'(4 * k));
        @(negedge clk);
        chk("redir_req", 32'(bus.imem_req), 0);
        drive(0, 0, 0, dbl, t2, 1);
        if (dbl) begin
            sb_q.delete();
            for (int k = 0; k < 3; k++) sb_q.push_back(t2 + 32'(4 * k));
        end
        @(negedge clk);
        chk("drain_req0", 32'(bus.imem_req), 0);
        chk("drain_vld", 32'(bus.if_valid), 0);
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("drain_req1", 32'(bus.imem_req), 0);
        drive(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("target_req", 32'(bus.imem_req), 1);
        chk("target_addr", bus.imem_addr, fin);
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        bus.stall = 1'b1;
        sb_en     = 1'b0;
        chk("sb_drained", 32'(sb_q.size()), 0);
    endtask

    row_t tbl [29];

    initial begin
        // rst stall flush br tgt gnt | req addr vld pc
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0);
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h4,         0, 32'h0);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'hC,         1, 32'h4);
        tbl[5]  = mk(0, 1, 0, 0, 32'h0,         1, 0, 32'h10,        1, 32'h8);
        tbl[6]  = mk(0, 1, 0, 0, 32'h0,         1, 0, 32'h10,        1, 32'h8);
        tbl[7]  = mk(0, 1, 0, 0, 32'h0,         1, 0, 32'h10,        1, 32'h8);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h10,        1, 32'h8);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h14,        1, 32'hC);
        tbl[10] = mk(0, 1, 1, 0, 32'hFFFF_FFF8, 1, 0, 32'h18,        1, 32'h10);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFF8, 0, 32'h0);
        tbl[12] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0);
        tbl[13] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h0,         1, 32'hFFFF_FFF8);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h4,         1, 32'hFFFF_FFFC);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h8,         1, 32'h0);
        tbl[16] = mk(0, 0, 0, 1, 32'h200,       1, 0, 32'hC,         1, 32'h4);
        tbl[17] = mk(0, 0, 0, 1, 32'h300,       1, 0, 32'h200,       0, 32'h0);
        tbl[18] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h300,       0, 32'h0);
        tbl[19] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h304,       0, 32'h0);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h308,       1, 32'h300);
        tbl[21] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h30C,       1, 32'h304);
        tbl[22] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h30C,       1, 32'h308);
        tbl[23] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h30C,       0, 32'h0);
        tbl[24] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h30C,       0, 32'h0);
        tbl[25] = mk(0, 0, 0, 0, 32'h0,         0, 1, 32'h30C,       0, 32'h0);
        tbl[26] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h30C,       0, 32'h0);
        tbl[27] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h310,       0, 32'h0);
        tbl[28] = mk(0, 0, 0, 0, 32'h0,         1, 1, 32'h314,       1, 32'h30C);

        rst               = 1'b1;
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.imem_gnt      = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 29; i++) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].br, tbl[i].tgt, tbl[i].gnt);
            @(negedge clk);
            chk($sformatf("r%0d_req", i),  32'(bus.imem_req), 32'(tbl[i].req));
            chk($sformatf("r%0d_addr", i), bus.imem_addr,     tbl[i].addr);
            chk($sformatf("r%0d_vld", i),  32'(bus.if_valid), 32'(tbl[i].vld));
            chk($sformatf("r%0d_pc", i),   bus.if_pc,         tbl[i].pc);
            chk($sformatf("r%0d_inst", i), bus.if_inst,       tbl[i].vld ? ~tbl[i].pc : NOP_INST);
        end

        drain_seq(32'h100, 1'b0, 32'h0);
        drain_seq(32'h100, 1'b1, 32'h180);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
